// File: rtl/segled_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: register map,
// control bit positions, segment bit positions and the hex glyph table.
package segled_pkg;

    localparam int ADDR_CTRL     = 8;

    localparam int CTRL_SCAN_EN  = 0;
    localparam int CTRL_HEX_MODE = 1;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Entry n is the a..g pattern for hex digit n; element 15 is listed first.
    localparam logic [15:0][6:0] HEX7_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/segled_scan_if.sv
// Register write bus shared with the other peripherals: one-cycle wr strobe,
// write address and 32-bit write data.
interface segled_scan_if #(
    parameter int ADDRESS_WIDTH = 5
);
    logic                     wr;
    logic [ADDRESS_WIDTH-1:0] waddr;
    logic [31:0]              wdata;

    modport master (output wr, output waddr, output wdata);
    modport slave  (input  wr, input  waddr, input  wdata);
endinterface

// File: rtl/segled_hex7.sv
// Combinational 4-bit to 7-segment (a..g) decoder; only instantiated when
// SEGLED_HEX_DECODE_EN is defined.
module segled_hex7
    import segled_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = HEX7_TABLE[nibble];
endmodule

// File: rtl/segled_scan.sv
// Multi-digit seven-segment scanner with per-digit segment registers and a dead
// cycle per digit slot. Optional hex decoding is built when SEGLED_HEX_DECODE_EN is defined.
module segled_scan
    import segled_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_DIGITS    = 4,
    parameter int SCAN_DIV      = 50000
)(
    input  logic                  clk,
    input  logic                  rstn,
    segled_scan_if.slave          bus,
    output logic [7:0]            segled_pin,
    output logic [NUM_DIGITS-1:0] digit_sel
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic                       ctrl_wr;
    logic [NUM_DIGITS-1:0][7:0] digit_all;
    logic [7:0]                 cur_digit;
    logic [7:0]                 seg_src;

    logic                  scan_en_q,  scan_en_d;
    logic [CNT_W-1:0]      scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]      idx_q,      idx_d;
    logic [7:0]            seg_q,      seg_d;
    logic [NUM_DIGITS-1:0] sel_q,      sel_d;

    assign ctrl_wr = bus.wr && (bus.waddr == ADDRESS_WIDTH'(ADDR_CTRL));

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [7:0] dig_q, dig_d;

            always_comb begin
                dig_d = dig_q;
                if (bus.wr && (bus.waddr == ADDRESS_WIDTH'(gi)))
                    dig_d = bus.wdata[7:0];
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) dig_q <= '0;
                else       dig_q <= dig_d;
            end

            assign digit_all[gi] = dig_q;
        end
    endgenerate

    always_comb begin
        cur_digit = '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (idx_q == IDX_W'(k)) cur_digit = digit_all[k];
    end

`ifdef SEGLED_HEX_DECODE_EN
    logic       hex_mode_q, hex_mode_d;
    logic [6:0] hex_seg;
    logic       unused_wdata;

    segled_hex7 u_hex7 (
        .nibble (cur_digit[3:0]),
        .seg    (hex_seg)
    );

    always_comb begin
        hex_mode_d = hex_mode_q;
        if (ctrl_wr) hex_mode_d = bus.wdata[CTRL_HEX_MODE];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) hex_mode_q <= 1'b0;
        else       hex_mode_q <= hex_mode_d;
    end

    // Decimal point passes through untouched; bits 6:4 of the digit are don't-care.
    assign seg_src      = hex_mode_q ? {cur_digit[SEG_DP], hex_seg} : cur_digit;
    assign unused_wdata = &{1'b0, bus.wdata[31:8]};
`else
    logic unused_wdata;

    assign seg_src      = cur_digit;
    assign unused_wdata = &{1'b0, bus.wdata[31:8]};
`endif

    always_comb begin
        scan_en_d  = ctrl_wr ? bus.wdata[CTRL_SCAN_EN] : scan_en_q;
        scan_cnt_d = scan_cnt_q;
        idx_d      = idx_q;
        if (scan_en_q) begin
            if (scan_cnt_q == CNT_LAST) begin
                scan_cnt_d = '0;
                idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                scan_cnt_d = scan_cnt_q + 1'b1;
            end
        end
        seg_d = seg_src;
        // Count 0 of each slot is the blanking cycle between digits.
        sel_d = (scan_en_q && (scan_cnt_q != '0)) ? (NUM_DIGITS'(1) << idx_q) : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scan_en_q  <= 1'b1;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            seg_q      <= '0;
            sel_q      <= '0;
        end else begin
            scan_en_q  <= scan_en_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            sel_q      <= sel_d;
        end
    end

    assign segled_pin = seg_q;
    assign digit_sel  = sel_q;

endmodule

// File: tb/tb_segled_scan.sv
// Randomised and directed bench for segled_scan against a slot-time reference
// model (NUM_DIGITS=4, SCAN_DIV=4).
module tb_segled_scan;
    localparam int AW = 5;
    localparam int ND = 4;
    localparam int SD = 4;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic [7:0]    segled_pin;
    logic [ND-1:0] digit_sel;

    segled_scan_if #(.ADDRESS_WIDTH(AW)) wbus ();

    segled_scan #(
        .ADDRESS_WIDTH (AW),
        .NUM_DIGITS    (ND),
        .SCAN_DIV      (SD)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (wbus),
        .segled_pin (segled_pin),
        .digit_sel  (digit_sel)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    string phase    = "reset";

    // Reference model: slot time t = digit*SD + count, advancing only while scanning.
    int            m_t;
    bit            m_en;
    bit            m_hex;
    logic [7:0]    m_dig [ND];
    logic [7:0]    exp_seg;
    logic [ND-1:0] exp_sel;
    logic [6:0]    glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s/%s: got %0h expected %0h", phase, tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_en = 1'b1; m_hex = 1'b0;
        for (int k = 0; k < ND; k++) m_dig[k] = 8'h00;
        exp_seg = 8'h00; exp_sel = '0;
    endtask

    function automatic logic [7:0] model_seg(input logic [7:0] d);
`ifdef SEGLED_HEX_DECODE_EN
        if (m_hex) return {d[7], glyph[d[3:0]]};
`endif
        return d;
    endfunction

    task automatic model_step(input logic w, input logic [AW-1:0] a, input logic [31:0] d);
        int digit = (m_t / SD) % ND;
        int count = m_t % SD;
        exp_seg = model_seg(m_dig[digit]);
        exp_sel = (m_en && count != 0) ? (ND'(1) << digit) : '0;
        if (m_en) m_t = (m_t + 1) % (SD * ND);
        if (w) begin
            if (int'(a) < ND) m_dig[a] = d[7:0];
            else if (int'(a) == 8) begin
                m_en = d[0];
`ifdef SEGLED_HEX_DECODE_EN
                m_hex = d[1];
`endif
            end
        end
    endtask

    // One clock: drive, let the edge happen, update model, compare on the falling edge.
    task automatic cyc(input logic w, input logic [AW-1:0] a, input logic [31:0] d);
        wbus.wr = w; wbus.waddr = a; wbus.wdata = d;
        if (w) $display("[%0t] %s: wr addr=%0d data=%08h", $time, phase, a, d);
        @(posedge clk);
        model_step(w, a, d);
        @(negedge clk);
        check("seg", 32'(segled_pin), 32'(exp_seg));
        check("sel", 32'(digit_sel),  32'(exp_sel));
        wbus.wr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 32'h0);
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [31:0]   rd;
        bit            found;

        wbus.wr = 1'b0; wbus.waddr = '0; wbus.wdata = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check("rst_seg", 32'(segled_pin), 32'h0);
        check("rst_sel", 32'(digit_sel),  32'h0);
        rstn = 1'b1;

        phase = "scan_idle";
        idle(3 * SD * ND);

        phase = "digits";
        cyc(1'b1, 5'd0, 32'h11); cyc(1'b1, 5'd1, 32'h22);
        cyc(1'b1, 5'd2, 32'h44); cyc(1'b1, 5'd3, 32'h88);
        idle(2 * SD * ND);

        phase = "freeze";
        for (int i = 0; i < 2 * SD && (m_t % SD) != 2; i++) idle(1);
        cyc(1'b1, 5'd8, 32'h0);
        idle(10);
        cyc(1'b1, 5'd8, 32'h1);
        idle(SD * ND);

        phase = "hex";
        cyc(1'b1, 5'd0, 32'h8A);
        cyc(1'b1, 5'd8, 32'h3);
        found = 1'b0;
        for (int i = 0; i < 3 * SD * ND && !found; i++) begin
            idle(1);
            if (digit_sel == ND'(1)) begin
                found = 1'b1;
`ifdef SEGLED_HEX_DECODE_EN
                check("digit0_glyph", 32'(segled_pin), 32'hF7);
`else
                check("digit0_raw", 32'(segled_pin), 32'h8A);
`endif
            end
        end
        if (!found) check("digit0_timeout", 32'h0, 32'h1);

        phase = "ignored";
        cyc(1'b1, 5'd5, $urandom);
        cyc(1'b1, 5'd9, $urandom);
        idle(2 * SD * ND);

        phase = "async_rst";
        for (int i = 0; i < 2 * SD * ND && m_t != 2 * SD + 2; i++) idle(1);
        check("reached_digit2", m_t, 2 * SD + 2);
        #2 rstn = 1'b0;
        #1;
        check("rst_now_seg", 32'(segled_pin), 32'h0);
        check("rst_now_sel", 32'(digit_sel),  32'h0);
        model_reset();
        @(negedge clk);
        check("rst_hold_sel", 32'(digit_sel), 32'h0);
        rstn = 1'b1;
        idle(SD * ND + 2);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            rd = $urandom;
            case ($urandom_range(0, 5))
                0, 1, 2: ra = AW'($urandom_range(0, ND - 1));
                3:       begin ra = 5'd8; if ($urandom_range(0, 3) != 0) rd[0] = 1'b1; end
                default: ra = AW'($urandom_range(0, 31));
            endcase
            cyc(($urandom_range(0, 2) == 0), ra, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
